// File: rtl/irq_controller.sv
// 16-source interrupt controller: edge-detected pending bits, byte-addressed
// priority/enable/pending registers, and a registered priority arbiter toward the CPU.
module irq_controller #(
    parameter logic [23:0] IRQ_PRI = 24'h2020,
    parameter logic [23:0] IRQ_ENA = 24'h2023,
    parameter logic [23:0] IRQ_ACT = 24'h2027
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] irq_sources,
    input  logic [1:0]  cpu_ilevel,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [3:0]  irq_vector,
    output logic [1:0]  irq_level
);

    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned PRI_W   = 2;
    localparam int unsigned VEC_W   = 4;
    localparam int unsigned BYTE_W  = 8;

    logic [NUM_SRC-1:0] pri;
    logic [NUM_SRC-1:0] ena;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] sample;
    logic               primed;

    logic hit_pri_l_c;
    logic hit_pri_h_c;
    logic hit_ena_l_c;
    logic hit_ena_h_c;
    logic hit_act_l_c;
    logic hit_act_h_c;

    logic               ack_take_c;
    logic [NUM_SRC-1:0] ack_mask_c;
    logic [NUM_SRC-1:0] w1c_mask_c;
    logic [NUM_SRC-1:0] edge_set_c;
    logic [NUM_SRC-1:0] pending_next_c;
    logic [NUM_SRC-1:0] candidate_c;

    logic               best_found_c;
    logic [VEC_W-1:0]   best_vec_c;
    logic [PRI_W-1:0]   best_lvl_c;
    logic [PRI_W-1:0]   grp_pri_c;

    // Reads are side-effect free, so the strobe carries no information here.
    logic unused_bus_read;
    assign unused_bus_read = bus_read;

    // Register address decode.
    always_comb begin
        hit_pri_l_c = (bus_address_in == IRQ_PRI);
        hit_pri_h_c = (bus_address_in == IRQ_PRI + 24'd1);
        hit_ena_l_c = (bus_address_in == IRQ_ENA);
        hit_ena_h_c = (bus_address_in == IRQ_ENA + 24'd1);
        hit_act_l_c = (bus_address_in == IRQ_ACT);
        hit_act_h_c = (bus_address_in == IRQ_ACT + 24'd1);
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        bus_data_out = '0;
        if (hit_pri_l_c) begin
            bus_data_out = pri[BYTE_W-1:0];
        end else if (hit_pri_h_c) begin
            bus_data_out = pri[NUM_SRC-1:BYTE_W];
        end else if (hit_ena_l_c) begin
            bus_data_out = ena[BYTE_W-1:0];
        end else if (hit_ena_h_c) begin
            bus_data_out = ena[NUM_SRC-1:BYTE_W];
        end else if (hit_act_l_c) begin
            bus_data_out = pending[BYTE_W-1:0];
        end else if (hit_act_h_c) begin
            bus_data_out = pending[NUM_SRC-1:BYTE_W];
        end
    end

    // Pending update: ack and W1C clear, a fresh rising edge wins over both.
    always_comb begin
        ack_take_c = irq_ack && irq_req;
        ack_mask_c = ack_take_c ? (NUM_SRC'(1) << irq_vector) : '0;
        w1c_mask_c = '0;
        if (bus_write && hit_act_l_c) begin
            w1c_mask_c[BYTE_W-1:0] = bus_data_in;
        end
        if (bus_write && hit_act_h_c) begin
            w1c_mask_c[NUM_SRC-1:BYTE_W] = bus_data_in;
        end
        // The first sample after reset only primes the edge detector.
        edge_set_c     = primed ? (irq_sources & ~sample) : '0;
        pending_next_c = (pending & ~ack_mask_c & ~w1c_mask_c) | edge_set_c;
    end

    // Arbiter: highest group priority above the CPU mask; ties to lowest index.
    // The source being acknowledged this cycle is hidden so it is never re-requested.
    always_comb begin
        candidate_c  = pending & ena & ~ack_mask_c;
        best_found_c = 1'b0;
        best_vec_c   = '0;
        best_lvl_c   = '0;
        grp_pri_c    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grp_pri_c = pri[(i / 2) * PRI_W +: PRI_W];
            if (candidate_c[i] && (grp_pri_c != '0) &&
                (grp_pri_c > cpu_ilevel) && (grp_pri_c > best_lvl_c)) begin
                best_found_c = 1'b1;
                best_vec_c   = VEC_W'(i);
                best_lvl_c   = grp_pri_c;
            end
        end
    end

    // Configuration registers.
    always_ff @(posedge clk) begin
        if (clk_ce) begin
            if (reset) begin
                pri <= '0;
                ena <= '0;
            end else if (bus_write) begin
                if (hit_pri_l_c) pri[BYTE_W-1:0]         <= bus_data_in;
                if (hit_pri_h_c) pri[NUM_SRC-1:BYTE_W]   <= bus_data_in;
                if (hit_ena_l_c) ena[BYTE_W-1:0]         <= bus_data_in;
                if (hit_ena_h_c) ena[NUM_SRC-1:BYTE_W]   <= bus_data_in;
            end
        end
    end

    // Pending, edge detector and registered CPU request.
    always_ff @(posedge clk) begin
        if (clk_ce) begin
            if (reset) begin
                pending    <= '0;
                sample     <= '0;
                primed     <= 1'b0;
                irq_req    <= 1'b0;
                irq_vector <= '0;
                irq_level  <= '0;
            end else begin
                pending    <= pending_next_c;
                sample     <= irq_sources;
                primed     <= 1'b1;
                irq_req    <= best_found_c;
                irq_vector <= best_vec_c;
                irq_level  <= best_lvl_c;
            end
        end
    end

endmodule
